// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the multicycle ALU.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_NOP = 4'd0;
  localparam logic [OP_W-1:0] ALU_NOT = 4'd1;
  localparam logic [OP_W-1:0] ALU_INC = 4'd2;
  localparam logic [OP_W-1:0] ALU_DEC = 4'd3;
  localparam logic [OP_W-1:0] ALU_MOV = 4'd4;
  localparam logic [OP_W-1:0] ALU_ADD = 4'd5;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd6;
  localparam logic [OP_W-1:0] ALU_AND = 4'd7;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SHL = 4'd9;
  localparam logic [OP_W-1:0] ALU_SHR = 4'd10;
  localparam logic [OP_W-1:0] ALU_MUL = 4'd11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// done_o pulses for one cycle once the full 2*WIDTH-bit product is in place.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [SH_W:0] LastCnt = (SH_W+1)'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SH_W:0]      cnt_q;
  logic               run_q;
  logic               done_q;

  // Operands are captured on start so later input changes cannot disturb the run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a_i};
        mplier_q <= b_i;
        cnt_q    <= '0;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// Datapath ALU with valid/ready handshakes, registered result and flags,
// and an iterative multiply that holds off new requests while it runs.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             illegal_op
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] OneVal   = WIDTH'(1);

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             flag_z_q, flag_c_q, flag_v_q, flag_n_q;
  logic             illegal_q;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic             mul_finish;

  logic [WIDTH-1:0] alu_res_d;
  logic             alu_c_d, alu_v_d, alu_z_d, alu_n_d, alu_illegal_d;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;

  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign mul_start  = accept && (op == ALU_MUL);
  assign mul_finish = (state_q == BUSY) && mul_done;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Single-cycle ops; carry/borrow come from the extra top bit of the WIDTH+1 sums,
  // and the shift extensions carry the last bit shifted out in their spare bit.
  always_comb begin
    b_eff         = ((op == ALU_INC) || (op == ALU_DEC)) ? OneVal : b;
    add_sum       = {1'b0, a} + {1'b0, b_eff};
    sub_diff      = {1'b0, a} - {1'b0, b_eff};
    shl_ext       = {1'b0, a} << b;
    shr_ext       = {a, 1'b0} >> b;
    alu_res_d     = '0;
    alu_c_d       = 1'b0;
    alu_v_d       = 1'b0;
    alu_illegal_d = 1'b0;
    case (op)
      ALU_NOP: alu_res_d = '0;
      ALU_NOT: alu_res_d = ~a;
      ALU_MOV: alu_res_d = a;
      ALU_AND: alu_res_d = a & b;
      ALU_OR:  alu_res_d = a | b;
      ALU_INC, ALU_ADD: begin
        alu_res_d = add_sum[WIDTH-1:0];
        alu_c_d   = add_sum[WIDTH];
        alu_v_d   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_DEC, ALU_SUB: begin
        alu_res_d = sub_diff[WIDTH-1:0];
        alu_c_d   = sub_diff[WIDTH];
        alu_v_d   = (a[WIDTH-1] != b_eff[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SHL: begin
        if (b <= WidthVal) begin
          alu_res_d = shl_ext[WIDTH-1:0];
          alu_c_d   = shl_ext[WIDTH];
        end
      end
      ALU_SHR: begin
        if (b <= WidthVal) begin
          alu_res_d = shr_ext[WIDTH:1];
          alu_c_d   = shr_ext[0];
        end
      end
      ALU_MUL: alu_res_d = '0;
      default: alu_illegal_d = 1'b1;
    endcase
    alu_z_d = !alu_illegal_d && (alu_res_d == '0);
    alu_n_d = alu_res_d[WIDTH-1];
  end

  // Output register: loads on a single-cycle accept or multiply completion,
  // otherwise holds everything and only retires out_valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      if (mul_start) begin
        state_q <= BUSY;
      end else if (mul_finish) begin
        state_q <= IDLE;
      end

      if (accept && (op != ALU_MUL)) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res_d;
        result_hi_q <= '0;
        flag_z_q    <= alu_z_d;
        flag_c_q    <= alu_c_d;
        flag_v_q    <= alu_v_d;
        flag_n_q    <= alu_n_d;
        illegal_q   <= alu_illegal_d;
      end else if (mul_finish) begin
        out_valid_q <= 1'b1;
        result_q    <= mul_prod[WIDTH-1:0];
        result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
        flag_z_q    <= (mul_prod[WIDTH-1:0] == '0);
        flag_c_q    <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
        flag_v_q    <= 1'b0;
        flag_n_q    <= mul_prod[WIDTH-1];
        illegal_q   <= 1'b0;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=16); inputs change and
// outputs are sampled on the falling clock edge.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result, result_hi;
  logic        flag_z, flag_c, flag_v, flag_n;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .illegal_op (illegal_op)
  );

  // Presents one request for a single edge and returns on the following falling edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 4'd0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n, illegal_op} !== 38'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got ov=%b r=%h hi=%h f=%b%b%b%b ill=%b expected all zero",
               out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n, illegal_op);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_ops();
    logic [3:0]  vOp [10] = '{ALU_ADD, ALU_SUB, ALU_DEC, ALU_NOP, ALU_NOT,
                              ALU_MOV, ALU_AND, ALU_OR,  ALU_ADD, ALU_INC};
    logic [15:0] vA  [10] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h1234, 16'h00FF,
                              16'h8000, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h7FFF};
    logic [15:0] vB  [10] = '{16'h0001, 16'h0001, 16'h0000, 16'h5678, 16'h0000,
                              16'h0000, 16'hFF00, 16'h00F0, 16'h0001, 16'h0000};
    logic [15:0] vR  [10] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hFF00,
                              16'h8000, 16'hF000, 16'h0FFF, 16'h0000, 16'h8000};
    logic [3:0]  vF  [10] = '{4'b0011, 4'b0101, 4'b0010, 4'b1000, 4'b0001,
                              4'b0001, 4'b0001, 4'b0000, 4'b1100, 4'b0011};
    for (int i = 0; i < 10; i++) begin
      issue(vOp[i], vA[i], vB[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL single_valid[%0d]: got %b expected 1", i, out_valid);
      end
      checks++;
      if (result !== vR[i]) begin
        failures++;
        $display("[TB] FAIL single_result[%0d]: got %h expected %h", i, result, vR[i]);
      end
      checks++;
      if ({flag_z, flag_c, flag_v, flag_n} !== vF[i]) begin
        failures++;
        $display("[TB] FAIL single_flags[%0d] zcvn: got %b expected %b", i,
                 {flag_z, flag_c, flag_v, flag_n}, vF[i]);
      end
      checks++;
      if ({result_hi, illegal_op} !== 17'h0) begin
        failures++;
        $display("[TB] FAIL single_hi_ill[%0d]: got hi=%h ill=%b expected 0", i, result_hi, illegal_op);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_valid_drop: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_shift();
    logic [3:0]  vOp [7] = '{ALU_SHL, ALU_SHL, ALU_SHL, ALU_SHR, ALU_SHR, ALU_SHL, ALU_SHR};
    logic [15:0] vA  [7] = '{16'h8001, 16'h8000, 16'hFFFF, 16'h0001, 16'h8000, 16'h1234, 16'h8000};
    logic [15:0] vB  [7] = '{16'd1, 16'd16, 16'd17, 16'd1, 16'd15, 16'd0, 16'd16};
    logic [15:0] vR  [7] = '{16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h1234, 16'h0000};
    logic [3:0]  vF  [7] = '{4'b0100, 4'b1000, 4'b1000, 4'b1100, 4'b0000, 4'b0000, 4'b1100};
    for (int i = 0; i < 7; i++) begin
      issue(vOp[i], vA[i], vB[i]);
      checks++;
      if ({out_valid, result} !== {1'b1, vR[i]}) begin
        failures++;
        $display("[TB] FAIL shift_result[%0d]: got ov=%b r=%h expected ov=1 r=%h", i, out_valid, result, vR[i]);
      end
      checks++;
      if ({flag_z, flag_c, flag_v, flag_n} !== vF[i]) begin
        failures++;
        $display("[TB] FAIL shift_flags[%0d] zcvn: got %b expected %b", i,
                 {flag_z, flag_c, flag_v, flag_n}, vF[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [15:0] vA  [3] = '{16'h0100, 16'hFFFF, 16'h1234};
    logic [15:0] vB  [3] = '{16'h0100, 16'hFFFF, 16'h0003};
    logic [15:0] vR  [3] = '{16'h0000, 16'h0001, 16'h369C};
    logic [15:0] vH  [3] = '{16'h0001, 16'hFFFE, 16'h0000};
    logic [3:0]  vF  [3] = '{4'b1100, 4'b0100, 4'b0000};
    int   lat;
    logic stallOk;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = ALU_MUL;
      a = vA[i];
      b = vB[i];
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op = ALU_ADD;
      a = 16'hFFFF;
      b = 16'hFFFF;
      lat = 0;
      stallOk = 1'b1;
      while (out_valid !== 1'b1 && lat < 40) begin
        if (in_ready !== 1'b0) stallOk = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 17) begin
        failures++;
        $display("[TB] FAIL mul_latency[%0d]: got %0d edges expected 17", i, lat);
      end
      checks++;
      if (stallOk !== 1'b1) begin
        failures++;
        $display("[TB] FAIL mul_in_ready_low[%0d]: got in_ready high while busy expected low", i);
      end
      checks++;
      if ({result_hi, result} !== {vH[i], vR[i]}) begin
        failures++;
        $display("[TB] FAIL mul_product[%0d]: got %h_%h expected %h_%h", i, result_hi, result, vH[i], vR[i]);
      end
      checks++;
      if ({flag_z, flag_c, flag_v, flag_n, illegal_op} !== {vF[i], 1'b0}) begin
        failures++;
        $display("[TB] FAIL mul_flags[%0d] zcvn_ill: got %b expected %b", i,
                 {flag_z, flag_c, flag_v, flag_n, illegal_op}, {vF[i], 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic stable;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = ALU_ADD;
    a = 16'h7FFF;
    b = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0001;
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 16'h8000 ||
          {flag_z, flag_c, flag_v, flag_n} !== 4'b0011) stable = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_hold: got changing outputs or in_ready=1 (now r=%h rdy=%b) expected r=8000 rdy=0",
               result, in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    op = ALU_MOV;
    a = 16'h00AA;
    checks++;
    if ({out_valid, result, flag_z, flag_c, flag_v, flag_n} !== {1'b1, 16'h0002, 4'b0000}) begin
      failures++;
      $display("[TB] FAIL b2b_first: got ov=%b r=%h expected ov=1 r=0002 flags 0000", out_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result} !== {1'b1, 16'h00AA}) begin
      failures++;
      $display("[TB] FAIL b2b_second: got ov=%b r=%h expected ov=1 r=00aa", out_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic neverRose;
    issue(ALU_MUL, 16'h0003, 16'h0005);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rst_mid_mul_state: got ov=%b rdy=%b expected ov=0 rdy=1", out_valid, in_ready);
    end
    neverRose = 1'b1;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0) neverRose = 1'b0;
    end
    checks++;
    if (neverRose !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_mul_no_result: got out_valid=1 after reset expected 0");
    end

    out_ready = 1'b0;
    issue(ALU_ADD, 16'h0001, 16'h0001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, result} !== 17'h0) begin
      failures++;
      $display("[TB] FAIL rst_pending: got ov=%b r=%h expected ov=0 r=0000", out_valid, result);
    end

    issue(4'd13, 16'hFFFF, 16'hFFFF);
    checks++;
    if ({out_valid, illegal_op, result, result_hi, flag_z, flag_c, flag_v, flag_n} !== {2'b11, 36'h0}) begin
      failures++;
      $display("[TB] FAIL illegal_13: got ov=%b ill=%b r=%h hi=%h zcvn=%b expected ov=1 ill=1 rest 0",
               out_valid, illegal_op, result, result_hi, {flag_z, flag_c, flag_v, flag_n});
    end
    issue(4'd15, 16'h0000, 16'h0000);
    checks++;
    if ({illegal_op, flag_z} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL illegal_15: got ill=%b z=%b expected ill=1 z=0", illegal_op, flag_z);
    end
    issue(ALU_MOV, 16'h0001, 16'h0000);
    checks++;
    if ({illegal_op, result} !== {1'b0, 16'h0001}) begin
      failures++;
      $display("[TB] FAIL illegal_clear: got ill=%b r=%h expected ill=0 r=0001", illegal_op, result);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
